dma_periph_modport: RTL and testbench

Peripheral-side request block for the DMA controller's peripheral handshake. It turns per-channel TX/RX event pulses from peripheral logic into level requests on `periph_tx_req` / `periph_rx_req` (channels 31..1). Each request is held until the DMA returns a one-cycle clear on `periph_tx_clr` / `periph_rx_clr`. Events arriving while a request is outstanding are queued per channel and re-issued as separate requests.

---
 rtl/dma_periph_modport_if.sv | 37 +++
 rtl/dma_periph_modport.sv | 70 +++++++
 tb/tb_dma_periph_modport.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dma_periph_modport_if.sv
// Peripheral/DMA handshake bundle: per-channel event pulses in, level requests and
// sticky overflow flags out. Channels are numbered 31..1; there is no bit 0.
interface dma_periph_modport_if;
    logic [31:1] tx_event;
    logic [31:1] rx_event;
    logic [31:1] periph_tx_clr;
    logic [31:1] periph_rx_clr;
    logic        ovf_clr;
    logic [31:1] periph_tx_req;
    logic [31:1] periph_rx_req;
    logic [31:1] tx_ovf;
    logic [31:1] rx_ovf;

    modport master (
        output tx_event,
        output rx_event,
        output periph_tx_clr,
        output periph_rx_clr,
        output ovf_clr,
        input  periph_tx_req,
        input  periph_rx_req,
        input  tx_ovf,
        input  rx_ovf
    );

    modport slave (
        input  tx_event,
        input  rx_event,
        input  periph_tx_clr,
        input  periph_rx_clr,
        input  ovf_clr,
        output periph_tx_req,
        output periph_rx_req,
        output tx_ovf,
        output rx_ovf
    );
endinterface

// File: rtl/dma_periph_modport.sv
// Turns per-channel TX/RX event pulses into held DMA request levels, queueing up to
// PEND_MAX extra events per slice and flagging any event that had to be dropped.
module dma_periph_modport #(
    parameter int PEND_MAX = 3
) (
    input logic                  clk,
    input logic                  reset,
    dma_periph_modport_if.slave  bus
);
    localparam logic [2:0] LP_PEND_MAX = 3'(PEND_MAX);

    // Slices 0..30 are TX channels 1..31, slices 31..61 are RX channels 1..31.
    logic [61:0] w_event;
    logic [61:0] w_clr;
    logic [61:0] w_req;
    logic [61:0] w_ovf;

    assign w_event = {bus.rx_event, bus.tx_event};
    assign w_clr   = {bus.periph_rx_clr, bus.periph_tx_clr};

    for (genvar g = 0; g < 62; g++) begin : g_slice
        logic       r_req;
        logic [2:0] r_pend;
        logic       r_ovf;
        logic       w_has_pend;
        logic       w_launch;
        logic       w_dec;
        logic       w_queue;
        logic       w_ovf_set;

        assign w_has_pend = (r_pend != 3'd0);
        assign w_launch   = !r_req & (w_has_pend | w_event[g]);
        assign w_dec      = w_launch & w_has_pend;
        // The event is only consumed directly when it launches an empty slice.
        assign w_queue    = w_event[g] & !(w_launch & !w_has_pend);
        // A launch from the queue frees a slot in the same cycle, so only a full
        // queue with no launch has to drop the incoming event.
        assign w_ovf_set  = w_queue & !w_dec & (r_pend == LP_PEND_MAX);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_req  <= 1'b0;
                r_pend <= 3'd0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_launch) begin
                    r_req <= 1'b1;
                end else if (r_req & w_clr[g]) begin
                    r_req <= 1'b0;
                end

                if (w_queue & !w_dec & !w_ovf_set) begin
                    r_pend <= r_pend + 3'd1;
                end else if (w_dec & !w_queue) begin
                    r_pend <= r_pend - 3'd1;
                end

                r_ovf <= w_ovf_set | (r_ovf & !bus.ovf_clr);
            end
        end

        assign w_req[g] = r_req;
        assign w_ovf[g] = r_ovf;
    end

    assign bus.periph_tx_req = w_req[30:0];
    assign bus.periph_rx_req = w_req[61:31];
    assign bus.tx_ovf        = w_ovf[30:0];
    assign bus.rx_ovf        = w_ovf[61:31];
endmodule

// File: tb/tb_dma_periph_modport.sv
// Directed bench for dma_periph_modport: each stimulus step queues its expected
// outputs, and a monitor compares them one edge later.
module tb_dma_periph_modport;
    typedef struct {
        string        name;
        logic [123:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t q[$];
    event chk_ev;

    logic [31:1] Z;
    logic [31:1] ALL;
    logic [31:1] ODD;
    logic [31:1] EVEN;

    dma_periph_modport_if bus ();

    dma_periph_modport #(.PEND_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:1] b(input int ch);
        logic [31:1] r;
        r = '0;
        r[ch] = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [31:1] tev, input logic [31:1] rev,
                         input logic [31:1] tcl, input logic [31:1] rcl, input logic oc);
        bus.tx_event      = tev;
        bus.rx_event      = rev;
        bus.periph_tx_clr = tcl;
        bus.periph_rx_clr = rcl;
        bus.ovf_clr       = oc;
    endtask

    task automatic step(input string nm,
                        input logic [31:1] tev, input logic [31:1] rev,
                        input logic [31:1] tcl, input logic [31:1] rcl, input logic oc,
                        input logic [31:1] etr, input logic [31:1] err,
                        input logic [31:1] eto, input logic [31:1] ero);
        exp_t e;
        @(negedge clk);
        drive(tev, rev, tcl, rcl, oc);
        e.name = nm;
        e.exp  = {etr, err, eto, ero};
        q.push_back(e);
    endtask

    // Monitor: one queued expectation per sampled edge (or per async check).
    initial begin
        exp_t         e;
        logic [123:0] act;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.periph_tx_req, bus.periph_rx_req, bus.tx_ovf, bus.rx_ovf};
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got {txreq,rxreq,txovf,rxovf}=%h expected %h",
                             e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        exp_t e;
        n_tests = 0;
        n_fail  = 0;
        Z   = '0;
        ALL = '1;
        ODD = '0;
        for (int i = 1; i <= 31; i += 2) ODD[i] = 1'b1;
        EVEN = ~ODD;

        reset = 1'b0;
        drive(Z, Z, Z, Z, 1'b0);
        #2;
        e.name = "reset_initial";
        e.exp  = '0;
        q.push_back(e);
        -> chk_ev;
        @(negedge clk);
        reset = 1'b1;

        // single handshake, TX channel 5
        step("hs_launch", b(5), Z, Z, Z, 1'b0, b(5), Z, Z, Z);
        step("hs_hold1",  Z, Z, Z, Z, 1'b0, b(5), Z, Z, Z);
        step("hs_hold2",  Z, Z, Z, Z, 1'b0, b(5), Z, Z, Z);
        step("hs_clr",    Z, Z, b(5), Z, 1'b0, Z, Z, Z, Z);
        step("hs_idle",   Z, Z, Z, Z, 1'b0, Z, Z, Z, Z);

        // queuing, RX channel 31
        step("q_e1",   Z, b(31), Z, Z, 1'b0, Z, b(31), Z, Z);
        step("q_e2",   Z, b(31), Z, Z, 1'b0, Z, b(31), Z, Z);
        step("q_e3",   Z, b(31), Z, Z, 1'b0, Z, b(31), Z, Z);
        step("q_e4",   Z, Z, Z, Z, 1'b0, Z, b(31), Z, Z);
        step("q_clr5", Z, Z, Z, b(31), 1'b0, Z, Z, Z, Z);
        step("q_re6",  Z, Z, Z, Z, 1'b0, Z, b(31), Z, Z);
        step("q_clr7", Z, Z, Z, b(31), 1'b0, Z, Z, Z, Z);
        step("q_re8",  Z, Z, Z, Z, 1'b0, Z, b(31), Z, Z);
        step("q_clr9", Z, Z, Z, b(31), 1'b0, Z, Z, Z, Z);
        step("q_end",  Z, Z, Z, Z, 1'b0, Z, Z, Z, Z);

        // overflow, TX channel 1, queue depth 3
        step("ovf_e1", b(1), Z, Z, Z, 1'b0, b(1), Z, Z, Z);
        step("ovf_e2", b(1), Z, Z, Z, 1'b0, b(1), Z, Z, Z);
        step("ovf_e3", b(1), Z, Z, Z, 1'b0, b(1), Z, Z, Z);
        step("ovf_e4", b(1), Z, Z, Z, 1'b0, b(1), Z, Z, Z);
        step("ovf_e5", b(1), Z, Z, Z, 1'b0, b(1), Z, b(1), Z);
        step("ovf_clr_vs_set", b(1), Z, Z, Z, 1'b1, b(1), Z, b(1), Z);
        step("ovf_clr",  Z, Z, Z, Z, 1'b1, b(1), Z, Z, Z);
        step("ovf_c1",   Z, Z, b(1), Z, 1'b0, Z, Z, Z, Z);
        step("ovf_r2",   Z, Z, Z, Z, 1'b0, b(1), Z, Z, Z);
        step("ovf_c2",   Z, Z, b(1), Z, 1'b0, Z, Z, Z, Z);
        step("ovf_r3",   Z, Z, Z, Z, 1'b0, b(1), Z, Z, Z);
        step("ovf_c3",   Z, Z, b(1), Z, 1'b0, Z, Z, Z, Z);
        step("ovf_r4",   Z, Z, Z, Z, 1'b0, b(1), Z, Z, Z);
        step("ovf_c4",   Z, Z, b(1), Z, 1'b0, Z, Z, Z, Z);
        step("ovf_done1", Z, Z, Z, Z, 1'b0, Z, Z, Z, Z);
        step("ovf_done2", Z, Z, Z, Z, 1'b0, Z, Z, Z, Z);

        // simultaneous event + clear on ch2, stray clear on idle ch3
        step("sim_launch",  b(2), Z, Z, Z, 1'b0, b(2), Z, Z, Z);
        step("sim_idleclr", Z, Z, b(3), Z, 1'b0, b(2), Z, Z, Z);
        step("sim_evclr",   b(2), Z, b(2), Z, 1'b0, Z, Z, Z, Z);
        step("sim_reissue", Z, Z, Z, Z, 1'b0, b(2), Z, Z, Z);
        step("sim_clr",     Z, Z, b(2), Z, 1'b0, Z, Z, Z, Z);
        step("sim_ch3_ev",  b(3), Z, Z, Z, 1'b0, b(3), Z, Z, Z);
        step("sim_ch3_clr", Z, Z, b(3), Z, 1'b0, Z, Z, Z, Z);
        step("sim_quiet",   Z, Z, Z, Z, 1'b0, Z, Z, Z, Z);

        // all 62 slices at once
        step("ind_all",   ALL, ALL, Z, Z, 1'b0, ALL, ALL, Z, Z);
        step("ind_odd",   Z, Z, ODD, ODD, 1'b0, EVEN, EVEN, Z, Z);
        step("ind_even",  Z, Z, EVEN, EVEN, 1'b0, Z, Z, Z, Z);

        // asynchronous reset mid-cycle with a queued event on TX ch7
        step("rst_e1", b(7), Z, Z, Z, 1'b0, b(7), Z, Z, Z);
        step("rst_e2", b(7), Z, b(7), Z, 1'b0, Z, Z, Z, Z);
        @(negedge clk);
        #2;
        drive(b(9), b(9), b(7), Z, 1'b0);
        reset = 1'b0;
        e.name = "reset_async";
        e.exp  = '0;
        q.push_back(e);
        -> chk_ev;
        @(negedge clk);
        drive(Z, Z, Z, Z, 1'b0);
        reset = 1'b1;
        step("rst_after1", Z, Z, Z, Z, 1'b0, Z, Z, Z, Z);
        step("rst_after2", Z, Z, Z, Z, 1'b0, Z, Z, Z, Z);

        @(negedge clk);
        drive(Z, Z, Z, Z, 1'b0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
